// File: rtl/pal_pkg.sv
// Shared definitions for the PAL array and its configuration loaders:
// loader FSM state encoding and the bitstream length helper.
package pal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_FIN  = 2'd3
  } pal_cfg_state_e;

  // AND-plane (2 literals per input per product) plus OR-plane bits.
  function automatic int pal_bs_len(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_tick.sv
// Phase counter for the PAL config clock: emits a one-cycle tick every DIV
// enabled cycles; clear restarts the phase from zero.
module pal_cfg_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PH_W = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [PH_W-1:0] phase_reg;

  // Tick is decoded from the registered phase so the FSM advances on the
  // last cycle of each phase.
  assign tick = en && (phase_reg == PH_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else if (clr) begin
      phase_reg <= '0;
    end else if (en) begin
      if (tick) begin
        phase_reg <= '0;
      end else begin
        phase_reg <= phase_reg + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// Serial configuration loader for the PAL array: shifts a parallel bitstream
// into CFG, LSB first, one bit per generated PAL_CLK pulse.
// Optional PARITY output enabled by defining PAL_CFG_PARITY_EN.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int  N      = 4,
  parameter int  M      = 1,
  parameter int  P      = 3,
  parameter int  DIV    = 1,
  localparam int BS_LEN = pal_bs_len(N, M, P)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [BS_LEN-1:0] BITSTREAM,
  output logic              BUSY,
  output logic              DONE,
  output logic              PAL_CLK,
`ifdef PAL_CFG_PARITY_EN
  output logic              PAL_CFG,
  output logic              PARITY
`else
  output logic              PAL_CFG
`endif
);

  localparam int CNT_W = $clog2(BS_LEN + 1);

  pal_cfg_state_e    state_reg;
  logic [BS_LEN-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              pal_clk_reg;
  logic              pal_cfg_reg;
`ifdef PAL_CFG_PARITY_EN
  logic              parity_reg;
`endif

  logic loading;
  logic tick_en;
  logic tick_clr;
  logic tick;
  logic last_bit;

  assign loading  = (state_reg == ST_LOW) || (state_reg == ST_HIGH);
  assign tick_en  = loading && !ABORT;
  assign tick_clr = !loading || ABORT;
  assign last_bit = (bit_cnt_reg == CNT_W'(BS_LEN - 1));

  pal_cfg_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      pal_clk_reg <= 1'b0;
      pal_cfg_reg <= 1'b0;
`ifdef PAL_CFG_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg    <= 1'b0;
          pal_clk_reg <= 1'b0;
          if (START) begin
            shift_reg   <= BITSTREAM;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            pal_cfg_reg <= BITSTREAM[0];
            state_reg   <= ST_LOW;
`ifdef PAL_CFG_PARITY_EN
            parity_reg  <= 1'b0;
`endif
          end else begin
            busy_reg    <= 1'b0;
            pal_cfg_reg <= 1'b0;
          end
        end

        ST_LOW: begin
          if (ABORT) begin
            busy_reg    <= 1'b0;
            pal_clk_reg <= 1'b0;
            pal_cfg_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (tick) begin
            pal_clk_reg <= 1'b1;
            state_reg   <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (ABORT) begin
            // The rising edge already happened, so this bit is in the PAL.
`ifdef PAL_CFG_PARITY_EN
            parity_reg  <= parity_reg ^ shift_reg[0];
`endif
            busy_reg    <= 1'b0;
            pal_clk_reg <= 1'b0;
            pal_cfg_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (tick) begin
            shift_reg   <= {1'b0, shift_reg[BS_LEN-1:1]};
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            pal_clk_reg <= 1'b0;
`ifdef PAL_CFG_PARITY_EN
            parity_reg  <= parity_reg ^ shift_reg[0];
`endif
            if (last_bit) begin
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              pal_cfg_reg <= 1'b0;
              state_reg   <= ST_FIN;
            end else begin
              pal_cfg_reg <= shift_reg[1];
              state_reg   <= ST_LOW;
            end
          end
        end

        ST_FIN: begin
          done_reg    <= 1'b0;
          busy_reg    <= 1'b0;
          pal_clk_reg <= 1'b0;
          pal_cfg_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end

        default: begin
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
          pal_clk_reg <= 1'b0;
          pal_cfg_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign PAL_CLK = pal_clk_reg;
  assign PAL_CFG = pal_cfg_reg;
`ifdef PAL_CFG_PARITY_EN
  assign PARITY  = parity_reg;
`endif

endmodule
